// File: rtl/line_raster.sv
// line_raster: Bresenham line rasteriser with screen clipping.
// The endpoints and colour are captured on start. One pixel is produced per
// DRAW cycle through a valid/ready handshake. Points outside the screen are
// stepped over without a handshake.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, x0, y0, x1, y1, color  line request (sampled in IDLE only)
//   px_valid, px_ready            pixel handshake with the framebuffer writer
//   px_x, px_y, px_color          pixel payload
//   busy                          high whenever the FSM is not in IDLE
//   done                          one-cycle pulse after the last point
module line_raster #(
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  x0,
    input  logic [9:0]  x1,
    input  logic [8:0]  y0,
    input  logic [8:0]  y1,
    input  logic [11:0] color,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [9:0]  px_x,
    output logic [8:0]  px_y,
    output logic [11:0] px_color,
    output logic        busy,
    output logic        done
);

    localparam int unsigned XW  = 10;
    localparam int unsigned YW  = 9;
    localparam int unsigned CW  = 12;
    localparam int unsigned CXW = XW + 1;
    localparam int unsigned CYW = YW + 1;
    localparam int unsigned DW  = 11;
    localparam int unsigned EW  = 12;
    localparam int unsigned E2W = 13;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_e;

    state_e                state_q, state_d;
    logic [XW-1:0]         x0_q, x0_d, x1_q, x1_d;
    logic [YW-1:0]         y0_q, y0_d, y1_q, y1_d;
    logic [CW-1:0]         col_q, col_d;
    logic [DW-1:0]         dx_q, dx_d;
    logic signed [DW-1:0]  dy_q, dy_d;
    logic                  sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic signed [EW-1:0]  err_q, err_d;
    logic [CXW-1:0]        cx_q, cx_d;
    logic [CYW-1:0]        cy_q, cy_d;

    // Bresenham decision terms, all taken from the pre-update error.
    logic signed [E2W-1:0] e2_c, dx13_c, dy13_c;
    logic                  step_x_c, step_y_c, visible_c, at_end_c, fire_c;
    logic [XW-1:0]         adx_c;
    logic [YW-1:0]         ady_c;

    assign e2_c      = {err_q, 1'b0};
    assign dx13_c    = $signed({2'b00, dx_q});
    assign dy13_c    = $signed({{2{dy_q[DW-1]}}, dy_q});
    assign step_x_c  = (e2_c >= dy13_c);
    assign step_y_c  = (e2_c <= dx13_c);
    assign visible_c = (cx_q < CXW'(H_RES)) && (cy_q < CYW'(V_RES));
    assign at_end_c  = (cx_q == {1'b0, x1_q}) && (cy_q == {1'b0, y1_q});
    // Clipped points never wait for the downstream writer.
    assign fire_c    = !visible_c || px_ready;
    assign adx_c     = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    assign ady_c     = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        x1_d     = x1_q;
        y0_d     = y0_q;
        y1_d     = y1_q;
        col_d    = col_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    x1_d    = x1;
                    y0_d    = y0;
                    y1_d    = y1;
                    col_d   = color;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                dx_d     = {1'b0, adx_c};
                dy_d     = $signed(DW'(0) - {2'b00, ady_c});
                sx_neg_d = !(x0_q < x1_q);
                sy_neg_d = !(y0_q < y1_q);
                err_d    = $signed({2'b00, adx_c}) - $signed({3'b000, ady_c});
                cx_d     = {1'b0, x0_q};
                cy_d     = {1'b0, y0_q};
                state_d  = DRAW;
            end
            DRAW: begin
                if (fire_c) begin
                    if (at_end_c) begin
                        state_d = DONE;
                    end else begin
                        err_d = err_q
                              + (step_x_c ? $signed({dy_q[DW-1], dy_q}) : EW'(0))
                              + (step_y_c ? $signed({1'b0, dx_q})       : EW'(0));
                        if (step_x_c) cx_d = sx_neg_q ? cx_q - CXW'(1) : cx_q + CXW'(1);
                        if (step_y_c) cy_d = sy_neg_q ? cy_q - CYW'(1) : cy_q + CYW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            col_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            x1_q     <= x1_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            col_q    <= col_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            err_q    <= err_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
        end
    end

    // Outputs are decoded straight from registers, so reset clears them at once.
    assign px_valid = (state_q == DRAW) && visible_c;
    assign px_x     = cx_q[XW-1:0];
    assign px_y     = cy_q[YW-1:0];
    assign px_color = col_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_line_raster.sv
// Directed bench for line_raster: hand-computed pixel sequences for
// horizontal, diagonal, steep, backpressured, clipped, single-point and
// reset-interrupted lines.
module tb_line_raster;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  x0, x1;
    logic [8:0]  y0, y1;
    logic [11:0] color;
    logic        px_valid;
    logic        px_ready;
    logic [9:0]  px_x;
    logic [8:0]  px_y;
    logic [11:0] px_color;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    line_raster #(.H_RES(640), .V_RES(480)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x0       (x0),
        .x1       (x1),
        .y0       (y0),
        .y1       (y1),
        .color    (color),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .px_x     (px_x),
        .px_y     (px_y),
        .px_color (px_color),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a line, scramble the inputs after capture, pass through SETUP.
    task automatic start_line(input int ax0, input int ay0, input int ax1,
                              input int ay1, input int col);
        x0    = 10'(ax0);
        y0    = 9'(ay0);
        x1    = 10'(ax1);
        y1    = 9'(ay1);
        color = 12'(col);
        start = 1'b1;
        tick();
        start = 1'b0;
        x0    = 10'd513;
        y0    = 9'd300;
        x1    = 10'd77;
        y1    = 9'd41;
        color = 12'hABC;
        chk("setup_busy", 32'(busy), 32'd1);
        chk("setup_valid", 32'(px_valid), 32'd0);
        tick();
    endtask

    // Expect a visible pixel now; it is accepted on the next edge if px_ready=1.
    task automatic pix(input int ex, input int ey, input int ec);
        chk("px_valid", 32'(px_valid), 32'd1);
        chk("px_x", 32'(px_x), 32'(ex));
        chk("px_y", 32'(px_y), 32'(ey));
        chk("px_color", 32'(px_color), 32'(ec));
        chk("no_done_in_draw", 32'(done), 32'd0);
        tick();
    endtask

    task automatic finish_line();
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_valid", 32'(px_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        tick();
        chk("done_clear", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        x0       = '0;
        x1       = '0;
        y0       = '0;
        y1       = '0;
        color    = '0;
        px_ready = 1'b1;

        // Reset state before any clock edge.
        #2;
        chk("rst_valid", 32'(px_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_px_x", 32'(px_x), 32'd0);
        chk("rst_px_y", 32'(px_y), 32'd0);
        chk("rst_px_color", 32'(px_color), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Horizontal line, one pixel per cycle.
        start_line(0, 0, 3, 0, 12'hF00);
        pix(0, 0, 12'hF00);
        pix(1, 0, 12'hF00);
        pix(2, 0, 12'hF00);
        pix(3, 0, 12'hF00);
        finish_line();

        // Steep line: err -2 -> (0,1) -> (1,2) -> (1,3).
        start_line(0, 0, 1, 3, 12'h00F);
        pix(0, 0, 12'h00F);
        pix(0, 1, 12'h00F);
        pix(1, 2, 12'h00F);
        pix(1, 3, 12'h00F);
        finish_line();

        // Backpressure: each pixel stalled 3 cycles then accepted.
        start_line(0, 0, 2, 0, 12'h0A5);
        for (int p = 0; p < 3; p++) begin
            px_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
                chk("stall_valid", 32'(px_valid), 32'd1);
                chk("stall_x", 32'(px_x), 32'(p));
                chk("stall_y", 32'(px_y), 32'd0);
                chk("stall_color", 32'(px_color), 32'h0A5);
                tick();
            end
            px_ready = 1'b1;
            pix(p, 0, 12'h0A5);
        end
        finish_line();

        // Clipping at the right edge: 640..642 skipped without handshake.
        start_line(638, 10, 642, 10, 12'h123);
        px_ready = 1'b1;
        pix(638, 10, 12'h123);
        pix(639, 10, 12'h123);
        for (int s = 0; s < 3; s++) begin
            chk("clip_valid", 32'(px_valid), 32'd0);
            chk("clip_busy", 32'(busy), 32'd1);
            chk("clip_done", 32'(done), 32'd0);
            tick();
        end
        finish_line();

        // Single point; start held and inputs changed while busy are ignored.
        x0    = 10'd7;
        y0    = 9'd7;
        x1    = 10'd7;
        y1    = 9'd7;
        color = 12'h0F0;
        start = 1'b1;
        tick();
        x0 = 10'd100;
        x1 = 10'd200;
        tick();
        pix(7, 7, 12'h0F0);
        start = 1'b0;
        finish_line();
        tick();
        chk("start_not_latched", 32'(busy), 32'd0);

        // Reset mid-line after two pixels.
        start_line(0, 0, 9, 0, 12'h777);
        pix(0, 0, 12'h777);
        pix(1, 0, 12'h777);
        chk("pre_rst_valid", 32'(px_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(px_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_px_x", 32'(px_x), 32'd0);
        chk("midrst_color", 32'(px_color), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 12; s++) begin
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_valid", 32'(px_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            tick();
        end

        // Reverse diagonal after reset: both steps every cycle.
        start_line(5, 5, 2, 2, 12'hFFF);
        pix(5, 5, 12'hFFF);
        pix(4, 4, 12'hFFF);
        pix(3, 3, 12'hFFF);
        pix(2, 2, 12'hFFF);
        finish_line();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
